// File: rtl/hdmi_pkg.sv
// ============================================================================
// Module      : hdmi_pkg
// Description : Shared types and constants for the HDMI pixel-source path.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package hdmi_pkg;

    localparam int BITS_PER_COLOR_DFLT = 8;
    localparam int FRAME_CNT_W         = 16;

    typedef enum logic [1:0] {
        SYNC = 2'd0,
        IDLE = 2'd1,
        OWN0 = 2'd2,
        OWN1 = 2'd3
    } arb_state_t;

endpackage

`default_nettype wire

// File: rtl/rr_pick2.sv
// ============================================================================
// Module      : rr_pick2
// Description : Combinational two-requester round-robin pick (one-hot result).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_pick2 (
    input  logic [1:0] req,
    input  logic       ptr,
    output logic [1:0] gnt
);

    // ptr names the source that wins a tie.
    always_comb begin
        gnt = req;
        if (req == 2'b11) begin
            gnt = ptr ? 2'b10 : 2'b01;
        end
    end

endmodule

`default_nettype wire

// File: rtl/pixel_src_arbiter.sv
// ============================================================================
// Module      : pixel_src_arbiter
// Description : Frame-granular round-robin arbiter between two pixel sources.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pixel_src_arbiter
    import hdmi_pkg::*;
#(
    parameter int BITS_PER_COLOR = BITS_PER_COLOR_DFLT
) (
    input  logic                           i_pixclk,
    input  logic                           i_reset,
    input  logic                           i_rd,
    input  logic                           i_newline,
    input  logic                           i_newframe,
    input  logic [1:0]                     i_req,
    input  logic [3*BITS_PER_COLOR-1:0]    i_pixel0,
    input  logic [3*BITS_PER_COLOR-1:0]    i_pixel1,
    output logic [1:0]                     o_rd,
    output logic [1:0]                     o_newline,
    output logic [1:0]                     o_newframe,
    output logic [3*BITS_PER_COLOR-1:0]    o_pixel,
    output logic [1:0]                     o_gnt,
    output logic [FRAME_CNT_W-1:0]         o_frame_cnt
);

    localparam int PW = 3 * BITS_PER_COLOR;

    arb_state_t             r_state;
    arb_state_t             w_state_nxt;
    logic                   r_ptr;
    logic                   w_ptr_nxt;
    logic [FRAME_CNT_W-1:0] r_frame_cnt;
    logic [1:0]             w_pick;
    logic [1:0]             w_own;
    logic [1:0]             w_route;

    rr_pick2 u_pick (
        .req (i_req),
        .ptr (r_ptr),
        .gnt (w_pick)
    );

    always_ff @(posedge i_pixclk or posedge i_reset) begin
        if (i_reset) begin
            r_state     <= SYNC;
            r_ptr       <= 1'b0;
            r_frame_cnt <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
            if (i_newframe) begin
                r_frame_cnt <= r_frame_cnt + FRAME_CNT_W'(1);
            end
        end
    end

    // Ownership only moves on a frame boundary; the winner hands the tie to the other source.
    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        if (i_newframe) begin
            case (w_pick)
                2'b01: begin
                    w_state_nxt = OWN0;
                    w_ptr_nxt   = 1'b1;
                end
                2'b10: begin
                    w_state_nxt = OWN1;
                    w_ptr_nxt   = 1'b0;
                end
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        w_own = 2'b00;
        case (r_state)
            OWN0:    w_own = 2'b01;
            OWN1:    w_own = 2'b10;
            default: w_own = 2'b00;
        endcase
    end

    // The boundary cycle already routes to the incoming owner.
    always_comb begin
        w_route = 2'b00;
        if (!i_reset) begin
            w_route = i_newframe ? w_pick : w_own;
        end
    end

    always_comb begin
        o_pixel = '0;
        if (w_route[0]) begin
            o_pixel = i_pixel0;
        end else if (w_route[1]) begin
            o_pixel = i_pixel1;
        end
    end

    assign o_rd        = {2{i_rd}}       & w_route;
    assign o_newline   = {2{i_newline}}  & w_route;
    assign o_newframe  = {2{i_newframe}} & w_route;
    assign o_gnt       = w_own;
    assign o_frame_cnt = r_frame_cnt;

    logic [PW-1:0] w_unused_pw;
    assign w_unused_pw = '0;

endmodule

`default_nettype wire

// File: tb/tb_pixel_src_arbiter.sv
// ============================================================================
// Module      : tb_pixel_src_arbiter
// Description : Self-checking bench for pixel_src_arbiter against a frame-level model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pixel_src_arbiter;

    localparam int BPC = 8;
    localparam int PW  = 3 * BPC;

    logic          clk;
    logic          rst;
    logic          rd, nl, nf;
    logic [1:0]    req;
    logic [PW-1:0] pix0, pix1;
    logic [1:0]    o_rd, o_newline, o_newframe, o_gnt;
    logic [PW-1:0] o_pixel;
    logic [15:0]   o_frame_cnt;

    int n_checks = 0;
    int n_errors = 0;

    // Model: current owner (-1 = none), source that wins a tie, frames seen.
    int m_owner  = -1;
    int m_prefer = 0;
    int m_cnt    = 0;

    pixel_src_arbiter #(.BITS_PER_COLOR(BPC)) dut (
        .i_pixclk    (clk),
        .i_reset     (rst),
        .i_rd        (rd),
        .i_newline   (nl),
        .i_newframe  (nf),
        .i_req       (req),
        .i_pixel0    (pix0),
        .i_pixel1    (pix1),
        .o_rd        (o_rd),
        .o_newline   (o_newline),
        .o_newframe  (o_newframe),
        .o_pixel     (o_pixel),
        .o_gnt       (o_gnt),
        .o_frame_cnt (o_frame_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] onehot(input int who);
        logic [1:0] v;
        v = 2'b00;
        if (who == 0) v = 2'b01;
        if (who == 1) v = 2'b10;
        return v;
    endfunction

    // One pixel clock: drive at the falling edge, check mid-cycle, advance the model at the rising edge.
    task automatic step(input logic r, input logic d, input logic l, input logic f, input logic [1:0] q);
        int            nxt;
        int            route;
        logic [PW-1:0] exp_pix;
        @(negedge clk);
        rst  = r;
        rd   = d;
        nl   = l;
        nf   = f;
        req  = q;
        pix0 = PW'($urandom);
        pix1 = PW'($urandom);
        #1;
        if (r) begin
            m_owner  = -1;
            m_prefer = 0;
            m_cnt    = 0;
        end
        nxt = m_owner;
        if (!r && f) begin
            if (q == 2'b11)      nxt = m_prefer;
            else if (q == 2'b01) nxt = 0;
            else if (q == 2'b10) nxt = 1;
            else                 nxt = -1;
        end
        route   = r ? -1 : (f ? nxt : m_owner);
        exp_pix = (route == 0) ? pix0 : (route == 1) ? pix1 : '0;
        chk("gnt",       32'(o_gnt),       32'(onehot(m_owner)));
        chk("frame_cnt", 32'(o_frame_cnt), 32'(m_cnt & 16'hFFFF));
        chk("rd",        32'(o_rd),        32'(d ? onehot(route) : 2'b00));
        chk("newline",   32'(o_newline),   32'(l ? onehot(route) : 2'b00));
        chk("newframe",  32'(o_newframe),  32'(f ? onehot(route) : 2'b00));
        chk("pixel",     32'(o_pixel),     32'(exp_pix));
        @(posedge clk);
        if (!r && f) begin
            m_owner = nxt;
            if (nxt >= 0) m_prefer = 1 - nxt;
            m_cnt = (m_cnt + 1) & 16'hFFFF;
        end
    endtask

    task automatic frame(input int len, input logic [1:0] q);
        step(1'b0, 1'b1, 1'b0, 1'b1, q);
        for (int i = 1; i < len; i++) begin
            step(1'b0, 1'($urandom), 1'($urandom_range(0, 7) == 0), 1'b0, 2'($urandom));
        end
    endtask

    initial begin
        logic [1:0] seq [4];
        seq[0] = 2'b01; seq[1] = 2'b10; seq[2] = 2'b01; seq[3] = 2'b10;
        rst = 1'b1; rd = 1'b0; nl = 1'b0; nf = 1'b0; req = 2'b00; pix0 = '0; pix1 = '0;

        step(1'b1, 1'b0, 1'b0, 1'b0, 2'b00);
        step(1'b1, 1'b1, 1'b1, 1'b1, 2'b11);

        // Requests before the first frame are ignored.
        for (int i = 0; i < 1000; i++) begin
            step(1'b0, 1'($urandom), 1'($urandom), 1'b0, 2'b01);
        end
        step(1'b0, 1'b1, 1'b0, 1'b1, 2'b01);
        #2;
        chk("first_gnt", 32'(o_gnt), 32'(2'b01));
        chk("first_cnt", 32'(o_frame_cnt), 32'd1);

        // Owner 0 keeps routing after its request drops mid-frame.
        for (int i = 1; i < 400; i++) begin
            step(1'b0, 1'b1, (i % 100) == 0, 1'b0, (i < 300) ? 2'b01 : 2'b10);
        end
        step(1'b0, 1'b1, 1'b0, 1'b1, 2'b10);
        #2;
        chk("handover_gnt", 32'(o_gnt), 32'(2'b10));

        // Both requesting: strict alternation.
        for (int k = 0; k < 4; k++) begin
            step(1'b0, 1'b1, 1'b0, 1'b1, 2'b11);
            #2;
            chk("rr_seq", 32'(o_gnt), 32'(seq[k]));
            for (int i = 0; i < 20; i++) step(1'b0, 1'($urandom), 1'b0, 1'b0, 2'b11);
        end

        // Idle frame leaves the tie-break untouched.
        step(1'b0, 1'b1, 1'b0, 1'b1, 2'b00);
        for (int i = 0; i < 20; i++) step(1'b0, 1'b1, 1'($urandom), 1'b0, 2'($urandom));
        step(1'b0, 1'b1, 1'b0, 1'b1, 2'b11);
        #2;
        chk("after_idle_gnt", 32'(o_gnt), 32'(2'b01));

        for (int i = 0; i < 400; i++) begin
            step(1'b0, 1'($urandom), 1'($urandom_range(0, 7) == 0),
                 1'($urandom_range(0, 15) == 0), 2'($urandom));
        end
        for (int k = 0; k < 5; k++) frame(int'($urandom_range(1, 12)), 2'($urandom));

        // Run the frame counter up to its wrap point.
        while (m_cnt != 16'hFFFF) begin
            step(1'b0, 1'($urandom), 1'b0, 1'b1, 2'($urandom));
        end
        step(1'b0, 1'b1, 1'b0, 1'b1, 2'b10);
        #2;
        chk("wrap_cnt", 32'(o_frame_cnt), 32'd0);
        chk("wrap_gnt", 32'(o_gnt), 32'(2'b10));

        // Mid-line reset clears grant and strobes immediately.
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 2'b10);
        step(1'b1, 1'b1, 1'b1, 1'b0, 2'b10);
        chk("rst_gnt", 32'(o_gnt), 32'd0);
        chk("rst_rd", 32'(o_rd), 32'd0);
        for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 1'b1, 1'b0, 2'b11);
        step(1'b0, 1'b1, 1'b1, 1'b1, 2'b11);
        #2;
        chk("resync_gnt", 32'(o_gnt), 32'(2'b01));
        chk("resync_cnt", 32'(o_frame_cnt), 32'd1);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 2'b00);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
